axis_rx_frame_gate: RTL and testbench
=====================================

Name: axis_rx_frame_gate

Overview:
Store-and-forward RX frame buffer between the Ethernet MAC RX streams (m_axis_rxd data, m_axis_rxs status) and the RDMA decapsulator.
- Frames are written speculatively into a circular buffer.
- Each frame is committed only when its status word reports good and its length matches; otherwise it is rolled back.
- Bad, overflowed and length-mismatched frames never reach m_axis_eth.
- Successor to the single-word RX pass-through slice, generalised in data width and buffer depth.

Parameters:
DATA_W, 32, stream data width in bits (multiple of 8, 32..128)
ADDR_W, 9, buffer depth = 2**ADDR_W beats
LEN_CHECK, 1, 1 = drop frame if counted bytes differ from status length field
GOOD_BIT, 0, index of "frame good" bit in status tdata[15:0]

Ports:
axis_clk  in  1  clock
axis_aresetn  in  1  reset, asynchronous assert, active-low
s_axis_tdata  in  DATA_W  RX data
s_axis_tkeep  in  DATA_W/8  byte enables (contiguous from LSB)
s_axis_tvalid  in  1  RX data valid
s_axis_tready  out  1  RX data ready
s_axis_tlast  in  1  end of frame
s_axis_rxs_tdata  in  32  status: [31:16] length in bytes, [15:0] flags
s_axis_rxs_tvalid  in  1  status valid
s_axis_rxs_tready  out  1  status ready
s_axis_rxs_tlast  in  1  ignored (single-word status)
m_axis_eth_tdata  out  DATA_W  committed frame data
m_axis_eth_tkeep  out  DATA_W/8  byte enables
m_axis_eth_tvalid  out  1  output valid
m_axis_eth_tready  in  1  output ready
m_axis_eth_tlast  out  1  end of frame
frame_done  out  1  1-cycle pulse on commit
frame_drop  out  1  1-cycle pulse on rollback
frame_len_bytes  out  16  length field of last accepted status word
good_cnt  out  16  committed frames, saturating
drop_cnt  out  16  dropped frames, saturating

Behaviour:
- Reset (asynchronous, active-low): all pointers 0, FSM RECV, all outputs 0, including both treadys and the counters.
- Pointers are ADDR_W+1 bits with a wrap bit:
  - wr_ptr: speculative write position.
  - wr_cmt: committed write position.
  - rd_ptr: read position.
  - full when wr_ptr and rd_ptr differ only in the MSB; empty for the reader when rd_ptr == wr_cmt.
- Write FSM:
  - RECV:
    - s_axis_tready = 1.
    - Each accepted beat is written at wr_ptr if not full, then wr_ptr++.
    - byte_cnt += popcount(tkeep), saturating at 16'hFFFF.
    - A beat that arrives when full sets ovf, is not written, and moves the FSM to DRAIN (or WAIT_STS if that beat has tlast).
    - An accepted tlast beat moves to WAIT_STS.
  - DRAIN: s_axis_tready = 1; beats are discarded until tlast, then WAIT_STS.
  - WAIT_STS:
    - s_axis_tready = 0, s_axis_rxs_tready = 1.
    - On status handshake, latch frame_len_bytes = tdata[31:16].
    - good = tdata[GOOD_BIT] && !ovf && (!LEN_CHECK || byte_cnt == tdata[31:16]).
    - If good: wr_cmt <= wr_ptr, frame_done pulse, good_cnt++.
    - Else: wr_ptr <= wr_cmt, frame_drop pulse, drop_cnt++.
    - Clear ovf and byte_cnt, return to RECV.
- s_axis_rxs_tready is 0 outside WAIT_STS. Status words arriving early are held off by the upstream FIFO.
- Zero-length frames cannot occur: the frame is delimited by a tlast beat.
- Read side:
  - Synchronous-read RAM feeds a 2-entry output skid/register stage. The stage presents data, keep and last stored per beat.
  - m_axis_eth_tvalid rises exactly 2 cycles after the commit cycle when the output stage and buffer were empty.
  - Full throughput: 1 beat/cycle while tready is held high.
  - Output is AXIS compliant: data is stable while valid && !ready.
- Simultaneous events:
  - Commit and read in the same cycle are legal; the reader sees the new wr_cmt on the next cycle.
  - Rollback never moves wr_ptr below wr_cmt, so data not yet read is untouched.
  - A write reaching full while the reader frees a slot that cycle still counts as full (conservative).
- A frame larger than the depth always overflows and is dropped. There is no deadlock: DRAIN keeps ready high.
- Counters saturate at 16'hFFFF and never wrap.

Decomposition:
- Shared package rdma_rx_pkg:
  - RXS_LEN_MSB/LSB = 31/16.
  - Default GOOD_BIT.
  - Write FSM state encoding (RECV, DRAIN, WAIT_STS).
- Sub-module rx_frame_ram: simple dual-port RAM, 2**ADDR_W x (DATA_W + DATA_W/8 + 1), one write port, one synchronous read port.

Test Plan:
- Single 64-byte good frame (16 beats, status 0x0040_0001) -> frame_done pulse, good_cnt = 1; 16 output beats identical to input, tlast on beat 16, tvalid 2 cycles after commit.
- Same frame with status 0x0040_0000 -> frame_drop pulse, drop_cnt = 1, no output beats; wr_ptr is restored so the next good frame is output intact.
- 61-byte frame (last tkeep = 4'b0001), status length 62, LEN_CHECK = 1 -> dropped. With length 61 -> committed, last output tkeep = 4'b0001.
- ADDR_W = 4, 20-beat frame -> ovf, DRAIN consumes all 20 beats, dropped. A following 8-beat good frame passes.
- Back-to-back good frames with m_axis_eth_tready toggling 1/0 randomly -> output stream equals concatenated input, no duplicates or loss, data stable while stalled.
- Reset asserted mid-frame (beat 5 of 16) -> all outputs 0 immediately. After release, the next good frame is output alone, good_cnt = 1.

Source files
------------

// File: rtl/rdma_rx_pkg.sv
// Shared definitions for the RDMA RX frame path.
package rdma_rx_pkg;

    // Location of the byte length inside the MAC RX status word.
    localparam int unsigned RXS_LEN_MSB      = 31;
    localparam int unsigned RXS_LEN_LSB      = 16;
    // Default position of the "frame good" flag in status tdata[15:0].
    localparam int unsigned GOOD_BIT_DEFAULT = 0;

    // Write-side frame FSM.
    typedef enum logic [1:0] {
        StRecv    = 2'd0,
        StDrain   = 2'd1,
        StWaitSts = 2'd2
    } wr_state_e;

    // Number of set bits in a (zero-extended) tkeep vector.
    function automatic logic [4:0] popcount16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) begin
            c = c + {4'b0000, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/rx_frame_ram.sv
// Simple dual-port frame buffer: one write port, one synchronous read port.
module rx_frame_ram #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned WORD_W = 37
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [WORD_W-1:0] rd_data_o
);

    logic [WORD_W-1:0] mem [2**ADDR_W];

    // Write port.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
    end

    // Registered read port; output only changes on an enabled read.
    always_ff @(posedge clk_i) begin
        if (rd_en_i) begin
            rd_data_o <= mem[rd_addr_i];
        end
    end

endmodule

// File: rtl/axis_rx_frame_gate.sv
// Store-and-forward RX frame gate: frames are written speculatively and only
// released to m_axis_eth once their status word reports good and length matches.
module axis_rx_frame_gate
    import rdma_rx_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_W    = 9,
    parameter bit          LEN_CHECK = 1'b1,
    parameter int unsigned GOOD_BIT  = GOOD_BIT_DEFAULT
) (
    input  logic                axis_clk,
    input  logic                axis_aresetn,
    input  logic [DATA_W-1:0]   s_axis_tdata,
    input  logic [DATA_W/8-1:0] s_axis_tkeep,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic                s_axis_tlast,
    input  logic [31:0]         s_axis_rxs_tdata,
    input  logic                s_axis_rxs_tvalid,
    output logic                s_axis_rxs_tready,
    input  logic                s_axis_rxs_tlast,
    output logic [DATA_W-1:0]   m_axis_eth_tdata,
    output logic [DATA_W/8-1:0] m_axis_eth_tkeep,
    output logic                m_axis_eth_tvalid,
    input  logic                m_axis_eth_tready,
    output logic                m_axis_eth_tlast,
    output logic                frame_done,
    output logic                frame_drop,
    output logic [15:0]         frame_len_bytes,
    output logic [15:0]         good_cnt,
    output logic [15:0]         drop_cnt
);

    localparam int unsigned KEEP_W = DATA_W / 8;
    localparam int unsigned WORD_W = DATA_W + KEEP_W + 1;

    typedef logic [ADDR_W:0] ptr_t;

    wr_state_e   state_q, state_d;
    ptr_t        wr_ptr_q, wr_ptr_d, wr_cmt_q, wr_cmt_d, rd_ptr_q, rd_ptr_d;
    logic [15:0] byte_cnt_q, byte_cnt_d, len_q, len_d;
    logic [15:0] good_q, good_d, dropc_q, dropc_d;
    logic        ovf_q, ovf_d, done_q, done_d, drop_q, drop_d;
    logic        tready_q, rxs_tready_q;
    logic        full, beat_acc, sts_acc, ram_we, frame_ok;
    logic [16:0] byte_sum;
    logic [15:0] byte_sat;

    logic              rd_empty, rd_issue, ram_vld_q, pop;
    logic [1:0]        occ_q, occ_d;
    logic [2:0]        in_flight;
    logic [WORD_W-1:0] ram_rdata, ent0_q, ent0_d, ent1_q, ent1_d;
    logic              unused_rxs;

    // Status tlast is meaningless for a single-word status stream.
    assign unused_rxs = ^{s_axis_rxs_tlast, s_axis_rxs_tdata};

    // Full is judged against the current read pointer (conservative).
    assign full     = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                      (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);
    assign beat_acc = s_axis_tvalid && tready_q;
    assign sts_acc  = s_axis_rxs_tvalid && rxs_tready_q;
    assign ram_we   = beat_acc && (state_q == StRecv) && !full;
    assign byte_sum = {1'b0, byte_cnt_q} + 17'(popcount16(16'(s_axis_tkeep)));
    assign byte_sat = byte_sum[16] ? 16'hFFFF : byte_sum[15:0];
    assign frame_ok = s_axis_rxs_tdata[GOOD_BIT] && !ovf_q &&
                      (!LEN_CHECK || byte_cnt_q == s_axis_rxs_tdata[RXS_LEN_MSB:RXS_LEN_LSB]);

    // Write FSM next state: speculative write, then commit or roll back on status.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        wr_cmt_d   = wr_cmt_q;
        byte_cnt_d = byte_cnt_q;
        ovf_d      = ovf_q;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        len_d      = len_q;
        good_d     = good_q;
        dropc_d    = dropc_q;
        unique case (state_q)
            StRecv: begin
                if (beat_acc) begin
                    if (full) begin
                        ovf_d   = 1'b1;
                        state_d = s_axis_tlast ? StWaitSts : StDrain;
                    end else begin
                        wr_ptr_d   = wr_ptr_q + ptr_t'(1);
                        byte_cnt_d = byte_sat;
                        if (s_axis_tlast) begin
                            state_d = StWaitSts;
                        end
                    end
                end
            end
            StDrain: begin
                if (beat_acc && s_axis_tlast) begin
                    state_d = StWaitSts;
                end
            end
            StWaitSts: begin
                if (sts_acc) begin
                    len_d = s_axis_rxs_tdata[RXS_LEN_MSB:RXS_LEN_LSB];
                    if (frame_ok) begin
                        wr_cmt_d = wr_ptr_q;
                        done_d   = 1'b1;
                        if (good_q != 16'hFFFF) good_d = good_q + 16'd1;
                    end else begin
                        wr_ptr_d = wr_cmt_q;
                        drop_d   = 1'b1;
                        if (dropc_q != 16'hFFFF) dropc_d = dropc_q + 16'd1;
                    end
                    ovf_d      = 1'b0;
                    byte_cnt_d = '0;
                    state_d    = StRecv;
                end
            end
            default: state_d = StRecv;
        endcase
    end

    // Read issue: keep stage occupancy plus the in-flight RAM read within 2 entries.
    assign rd_empty  = (rd_ptr_q == wr_cmt_q);
    assign pop       = (occ_q != 2'd0) && m_axis_eth_tready;
    assign in_flight = {1'b0, occ_q} + {2'b00, ram_vld_q} - {2'b00, pop};
    assign rd_issue  = !rd_empty && (in_flight < 3'd2);
    assign rd_ptr_d  = rd_issue ? rd_ptr_q + ptr_t'(1) : rd_ptr_q;

    // Two-entry output stage; entry 0 is always the head presented downstream.
    always_comb begin
        ent0_d = ent0_q;
        ent1_d = ent1_q;
        occ_d  = occ_q;
        unique case ({ram_vld_q, pop})
            2'b11: begin
                if (occ_q == 2'd2) begin
                    ent0_d = ent1_q;
                    ent1_d = ram_rdata;
                end else begin
                    ent0_d = ram_rdata;
                end
            end
            2'b01: begin
                ent0_d = ent1_q;
                occ_d  = occ_q - 2'd1;
            end
            2'b10: begin
                if (occ_q == 2'd0) ent0_d = ram_rdata;
                else               ent1_d = ram_rdata;
                occ_d = occ_q + 2'd1;
            end
            default: ;
        endcase
    end

    // State registers; readies are registered so they read 0 throughout reset.
    always_ff @(posedge axis_clk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            state_q      <= StRecv;
            wr_ptr_q     <= '0;
            wr_cmt_q     <= '0;
            rd_ptr_q     <= '0;
            byte_cnt_q   <= '0;
            ovf_q        <= 1'b0;
            done_q       <= 1'b0;
            drop_q       <= 1'b0;
            len_q        <= '0;
            good_q       <= '0;
            dropc_q      <= '0;
            tready_q     <= 1'b0;
            rxs_tready_q <= 1'b0;
            ram_vld_q    <= 1'b0;
            occ_q        <= '0;
            ent0_q       <= '0;
            ent1_q       <= '0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            wr_cmt_q     <= wr_cmt_d;
            rd_ptr_q     <= rd_ptr_d;
            byte_cnt_q   <= byte_cnt_d;
            ovf_q        <= ovf_d;
            done_q       <= done_d;
            drop_q       <= drop_d;
            len_q        <= len_d;
            good_q       <= good_d;
            dropc_q      <= dropc_d;
            tready_q     <= (state_d != StWaitSts);
            rxs_tready_q <= (state_d == StWaitSts);
            ram_vld_q    <= rd_issue;
            occ_q        <= occ_d;
            ent0_q       <= ent0_d;
            ent1_q       <= ent1_d;
        end
    end

    rx_frame_ram #(
        .ADDR_W (ADDR_W),
        .WORD_W (WORD_W)
    ) u_ram (
        .clk_i     (axis_clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_ptr_q[ADDR_W-1:0]),
        .wr_data_i ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
        .rd_en_i   (rd_issue),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (ram_rdata)
    );

    assign s_axis_tready     = tready_q;
    assign s_axis_rxs_tready = rxs_tready_q;
    assign m_axis_eth_tvalid = (occ_q != 2'd0);
    assign m_axis_eth_tdata  = ent0_q[DATA_W-1:0];
    assign m_axis_eth_tkeep  = ent0_q[DATA_W +: KEEP_W];
    assign m_axis_eth_tlast  = ent0_q[WORD_W-1];
    assign frame_done        = done_q;
    assign frame_drop        = drop_q;
    assign frame_len_bytes   = len_q;
    assign good_cnt          = good_q;
    assign drop_cnt          = dropc_q;

endmodule

// File: tb/tb_axis_rx_frame_gate.sv
// Bench for axis_rx_frame_gate: a default-depth instance and an ADDR_W=4
// instance share stimulus; sel_small routes valids and selects outputs.
`timescale 1ns/1ps
module tb_axis_rx_frame_gate;

    typedef logic [36:0] beat_t;

    logic axis_clk = 1'b0;
    logic axis_aresetn = 1'b1;
    always #5 axis_clk = ~axis_clk;

    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '0;
    logic        tvalid = 1'b0, tlast = 1'b0;
    logic [31:0] rxs_tdata = '0;
    logic        rxs_tvalid = 1'b0;
    logic        m_tready = 1'b1;
    logic        sel_small = 1'b0;
    bit          rand_ready = 1'b0;

    logic        b_tready, b_rxs_tready, b_mv, b_ml, b_done, b_drop;
    logic [31:0] b_md;
    logic [3:0]  b_mk;
    logic [15:0] b_len, b_good, b_dropc;
    logic        s_tready, s_rxs_tready, s_mv, s_ml, s_done, s_drop;
    logic [31:0] s_md;
    logic [3:0]  s_mk;
    logic [15:0] s_len, s_good, s_dropc;

    logic        tready_m, rxs_tready_m, mv, done_m, drop_m;
    logic [15:0] len_m, good_m, dropc_m;
    beat_t       m_beat;

    assign tready_m     = sel_small ? s_tready : b_tready;
    assign rxs_tready_m = sel_small ? s_rxs_tready : b_rxs_tready;
    assign mv           = sel_small ? s_mv : b_mv;
    assign m_beat       = sel_small ? {s_ml, s_mk, s_md} : {b_ml, b_mk, b_md};
    assign done_m       = sel_small ? s_done : b_done;
    assign drop_m       = sel_small ? s_drop : b_drop;
    assign len_m        = sel_small ? s_len : b_len;
    assign good_m       = sel_small ? s_good : b_good;
    assign dropc_m      = sel_small ? s_dropc : b_dropc;

    axis_rx_frame_gate #(.DATA_W(32), .ADDR_W(9), .LEN_CHECK(1'b1), .GOOD_BIT(0)) u_big (
        .axis_clk(axis_clk), .axis_aresetn(axis_aresetn),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid && !sel_small),
        .s_axis_tready(b_tready), .s_axis_tlast(tlast),
        .s_axis_rxs_tdata(rxs_tdata), .s_axis_rxs_tvalid(rxs_tvalid && !sel_small),
        .s_axis_rxs_tready(b_rxs_tready), .s_axis_rxs_tlast(1'b1),
        .m_axis_eth_tdata(b_md), .m_axis_eth_tkeep(b_mk), .m_axis_eth_tvalid(b_mv),
        .m_axis_eth_tready(m_tready), .m_axis_eth_tlast(b_ml),
        .frame_done(b_done), .frame_drop(b_drop), .frame_len_bytes(b_len),
        .good_cnt(b_good), .drop_cnt(b_dropc)
    );

    axis_rx_frame_gate #(.DATA_W(32), .ADDR_W(4), .LEN_CHECK(1'b1), .GOOD_BIT(0)) u_small (
        .axis_clk(axis_clk), .axis_aresetn(axis_aresetn),
        .s_axis_tdata(tdata), .s_axis_tkeep(tkeep), .s_axis_tvalid(tvalid && sel_small),
        .s_axis_tready(s_tready), .s_axis_tlast(tlast),
        .s_axis_rxs_tdata(rxs_tdata), .s_axis_rxs_tvalid(rxs_tvalid && sel_small),
        .s_axis_rxs_tready(s_rxs_tready), .s_axis_rxs_tlast(1'b1),
        .m_axis_eth_tdata(s_md), .m_axis_eth_tkeep(s_mk), .m_axis_eth_tvalid(s_mv),
        .m_axis_eth_tready(m_tready), .m_axis_eth_tlast(s_ml),
        .frame_done(s_done), .frame_drop(s_drop), .frame_len_bytes(s_len),
        .good_cnt(s_good), .drop_cnt(s_dropc)
    );

    int    errors = 0;
    int    checks = 0;
    int    exp_good = 0;
    int    exp_drop = 0;
    beat_t exp_q[$];
    beat_t exp_beat;
    beat_t held;
    logic  stall_prev = 1'b0;

    // Output ready: held high, or randomly toggled after each edge.
    always @(posedge axis_clk) begin
        #1;
        m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Scoreboard monitor: samples mid-cycle, compares each handshake beat and
    // checks the head stays stable while stalled.
    always @(negedge axis_clk) begin
        if (axis_aresetn) begin
            if (stall_prev) begin
                checks++;
                if (!(mv === 1'b1 && m_beat === held)) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b beat=%h required valid=1 beat=%h",
                             mv, m_beat, held);
                end
            end
            if (mv === 1'b1 && m_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat got=%h required=no beat", m_beat);
                end else begin
                    exp_beat = exp_q.pop_front();
                    if (m_beat !== exp_beat) begin
                        errors++;
                        $display("FAIL out_beat got=%h required=%h", m_beat, exp_beat);
                    end
                end
            end
            stall_prev = (mv === 1'b1) && !m_tready;
            held       = m_beat;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic step();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic send_frame(input int nbeats, input logic [3:0] last_keep,
                              input logic [31:0] base, input bit expect_out);
        int waitc;
        for (int i = 0; i < nbeats; i++) begin
            tdata  = base + 32'(i);
            tkeep  = (i == nbeats - 1) ? last_keep : 4'hF;
            tlast  = (i == nbeats - 1);
            tvalid = 1'b1;
            waitc  = 0;
            while (!tready_m && waitc < 200) begin
                step();
                waitc++;
            end
            if (!tready_m) begin
                checks++;
                errors++;
                $display("FAIL data_ready_timeout got ready=0 required ready=1 beat=%0d", i);
                tvalid = 1'b0;
                tlast  = 1'b0;
                return;
            end
            if (expect_out) exp_q.push_back({tlast, tkeep, tdata});
            step();
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic send_status(input logic [31:0] word);
        int waitc;
        rxs_tdata  = word;
        rxs_tvalid = 1'b1;
        waitc      = 0;
        while (!rxs_tready_m && waitc < 200) begin
            step();
            waitc++;
        end
        if (!rxs_tready_m) begin
            checks++;
            errors++;
            $display("FAIL status_ready_timeout got ready=0 required ready=1");
        end else begin
            step();
        end
        rxs_tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            step();
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout got pending=%0d required pending=0", exp_q.size());
            exp_q.delete();
        end
        repeat (6) step();
    endtask

    task automatic test_reset();
        #2 axis_aresetn = 1'b0;
        #1;
        checks++;
        if ({b_tready, b_rxs_tready, b_mv, b_done, b_drop, b_good, b_dropc, b_len} !== '0) begin
            errors++;
            $display("FAIL reset_outputs got rdy=%b srdy=%b v=%b good=%0d drop=%0d required all 0",
                     b_tready, b_rxs_tready, b_mv, b_good, b_dropc);
        end
        step();
        step();
        axis_aresetn = 1'b1;
        step();
        step();
        checks++;
        if (b_tready !== 1'b1 || b_rxs_tready !== 1'b0) begin
            errors++;
            $display("FAIL ready_after_reset got tready=%b rxs_tready=%b required 1/0",
                     b_tready, b_rxs_tready);
        end
    endtask

    // 64-byte frame, commit latency and pulse width.
    task automatic test_single();
        send_frame(16, 4'hF, 32'h1000_0000, 1'b1);
        send_status(32'h0040_0001);
        exp_good++;
        checks++;
        if (done_m !== 1'b1 || drop_m !== 1'b0) begin
            errors++;
            $display("FAIL single_done got done=%b drop=%b required 1/0", done_m, drop_m);
        end
        checks++;
        if (good_m !== 16'(exp_good) || len_m !== 16'd64) begin
            errors++;
            $display("FAIL single_counts got good=%0d len=%0d required good=%0d len=64",
                     good_m, len_m, exp_good);
        end
        checks++;
        if (mv !== 1'b0) begin
            errors++;
            $display("FAIL latency_c0 got valid=%b required 0", mv);
        end
        step();
        checks++;
        if (mv !== 1'b0 || done_m !== 1'b0) begin
            errors++;
            $display("FAIL latency_c1 got valid=%b done=%b required 0/0", mv, done_m);
        end
        step();
        checks++;
        if (mv !== 1'b1) begin
            errors++;
            $display("FAIL latency_c2 got valid=%b required 1", mv);
        end
        wait_drain();
    endtask

    // Bad status is dropped and the following good frame survives intact.
    task automatic test_bad_status();
        send_frame(16, 4'hF, 32'h2000_0000, 1'b0);
        send_status(32'h0040_0000);
        exp_drop++;
        checks++;
        if (drop_m !== 1'b1 || done_m !== 1'b0 || dropc_m !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL bad_drop got drop=%b done=%b drop_cnt=%0d required 1/0/%0d",
                     drop_m, done_m, dropc_m, exp_drop);
        end
        repeat (6) step();
        checks++;
        if (mv !== 1'b0) begin
            errors++;
            $display("FAIL bad_no_output got valid=%b required 0", mv);
        end
        send_frame(16, 4'hF, 32'h3000_0000, 1'b1);
        send_status(32'h0040_0001);
        exp_good++;
        wait_drain();
        checks++;
        if (good_m !== 16'(exp_good)) begin
            errors++;
            $display("FAIL bad_then_good got good_cnt=%0d required %0d", good_m, exp_good);
        end
    endtask

    // 61-byte frame against length 62 (drop) and 61 (commit).
    task automatic test_len_check();
        send_frame(16, 4'h1, 32'h4000_0000, 1'b0);
        send_status(32'h003E_0001);
        exp_drop++;
        checks++;
        if (drop_m !== 1'b1 || len_m !== 16'd62) begin
            errors++;
            $display("FAIL len_mismatch got drop=%b len=%0d required 1/62", drop_m, len_m);
        end
        send_frame(16, 4'h1, 32'h5000_0000, 1'b1);
        send_status(32'h003D_0001);
        exp_good++;
        checks++;
        if (done_m !== 1'b1 || len_m !== 16'd61) begin
            errors++;
            $display("FAIL len_match got done=%b len=%0d required 1/61", done_m, len_m);
        end
        wait_drain();
    endtask

    // Depth-16 instance: 20-beat frame overflows, then an 8-beat frame passes.
    task automatic test_overflow();
        sel_small = 1'b1;
        step();
        send_frame(20, 4'hF, 32'h6000_0000, 1'b0);
        send_status(32'h0050_0001);
        checks++;
        if (drop_m !== 1'b1 || done_m !== 1'b0 || dropc_m !== 16'd1) begin
            errors++;
            $display("FAIL ovf_drop got drop=%b done=%b drop_cnt=%0d required 1/0/1",
                     drop_m, done_m, dropc_m);
        end
        send_frame(8, 4'hF, 32'h7000_0000, 1'b1);
        send_status(32'h0020_0001);
        wait_drain();
        checks++;
        if (good_m !== 16'd1) begin
            errors++;
            $display("FAIL ovf_then_good got good_cnt=%0d required 1", good_m);
        end
        sel_small = 1'b0;
        step();
    endtask

    // Back-to-back good frames with random output back-pressure.
    task automatic test_back_to_back();
        int n;
        int kn;
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            n  = $urandom_range(1, 12);
            kn = $urandom_range(1, 4);
            send_frame(n, 4'hF >> (4 - kn), 32'h8000_0000 + 32'(f << 8), 1'b1);
            send_status({16'((n - 1) * 4 + kn), 16'h0001});
            exp_good++;
        end
        wait_drain();
        rand_ready = 1'b0;
        checks++;
        if (good_m !== 16'(exp_good) || dropc_m !== 16'(exp_drop)) begin
            errors++;
            $display("FAIL b2b_counts got good=%0d drop=%0d required %0d/%0d",
                     good_m, dropc_m, exp_good, exp_drop);
        end
    endtask

    // Reset in the middle of a frame, then a clean frame afterwards.
    task automatic test_reset_mid();
        int waitc;
        for (int i = 0; i < 5; i++) begin
            tdata  = 32'h9000_0000 + 32'(i);
            tkeep  = 4'hF;
            tlast  = 1'b0;
            tvalid = 1'b1;
            waitc  = 0;
            while (!tready_m && waitc < 200) begin
                step();
                waitc++;
            end
            step();
        end
        #2 axis_aresetn = 1'b0;
        #1;
        tvalid = 1'b0;
        checks++;
        if ({b_tready, b_rxs_tready, b_mv, b_md, b_mk, b_ml, b_done, b_drop, b_len, b_good,
             b_dropc} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs got rdy=%b good=%0d drop=%0d len=%0d required all 0",
                     b_tready, b_good, b_dropc, b_len);
        end
        step();
        axis_aresetn = 1'b1;
        exp_good = 0;
        exp_drop = 0;
        step();
        send_frame(16, 4'hF, 32'hA000_0000, 1'b1);
        send_status(32'h0040_0001);
        exp_good++;
        wait_drain();
        checks++;
        if (good_m !== 16'(exp_good) || dropc_m !== 16'd0) begin
            errors++;
            $display("FAIL midreset_counts got good=%0d drop=%0d required 1/0", good_m, dropc_m);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_bad_status();
        test_len_check();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog got running required finished");
        $fatal(1, "watchdog expired");
    end

endmodule
